// File: rtl/ebr_bank_controller_pkg.sv
// Shared defaults and write-FSM encoding for the double-buffered EBR bank controller.
package ebr_bank_controller_pkg;

  localparam int EBR_DEPTH  = 512;
  localparam int EBR_ADDR_W = 9;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_FILL   = 2'd1,
    W_COMMIT = 2'd2
  } w_state_e;

endpackage

// File: rtl/ebr_bank_controller_status.sv
// Per-bank bookkeeping: committed-image valid flag, committed length and reader lock.
module ebr_bank_status
  import ebr_bank_controller_pkg::*;
#(
  parameter int LEN_W = EBR_ADDR_W + 1
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             fill_start,
  input  logic             commit,
  input  logic [LEN_W-1:0] commit_len,
  input  logic             grant_set,
  input  logic             drop,
  input  logic             consume,
  output logic             valid,
  output logic [LEN_W-1:0] len,
  output logic             locked
);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid  <= 1'b0;
      len    <= '0;
      locked <= 1'b0;
    end else begin
      // A commit outranks a same-cycle consume from the reader.
      if (commit) begin
        valid <= 1'b1;
        len   <= commit_len;
      end else if (fill_start || consume) begin
        valid <= 1'b0;
      end

      if (grant_set) begin
        locked <= 1'b1;
      end else if (drop || consume) begin
        locked <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ebr_bank_controller.sv
// Ping-pong controller: fills one EBR bank from the I2C writer while a consumer owns the other.
module ebr_bank_controller #(
  parameter int EBR_DEPTH  = ebr_bank_controller_pkg::EBR_DEPTH,
  parameter int EBR_ADDR_W = ebr_bank_controller_pkg::EBR_ADDR_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_active,
  input  logic                  ebr_select,
  input  logic                  ebr_wren,
  input  logic [7:0]            ebr_data_in,
  output logic                  bank0_wren,
  output logic                  bank1_wren,
  output logic [EBR_ADDR_W-1:0] wr_addr,
  output logic [7:0]            wr_data,
  input  logic                  rd_req,
  input  logic                  rd_bank,
  input  logic                  rd_done,
  output logic                  rd_grant,
  output logic [1:0]            bank_valid,
  output logic [EBR_ADDR_W:0]   bank0_len,
  output logic [EBR_ADDR_W:0]   bank1_len,
  output logic                  err_overflow,
  output logic                  err_collision,
  input  logic                  err_clear
);

  import ebr_bank_controller_pkg::*;

  localparam int               LEN_W      = EBR_ADDR_W + 1;
  localparam logic [LEN_W-1:0] FULL_COUNT = LEN_W'(EBR_DEPTH);

  w_state_e         state;
  w_state_e         state_next;
  logic             write_active_q;
  logic             rise;
  logic             pend;
  logic             pend_sel;
  logic             fill_bank;
  logic [LEN_W-1:0] count;
  logic             collided;

  logic             fill_start;
  logic             start_sel;
  logic             do_write;
  logic             ovf_evt;
  logic             col_evt;
  logic             commit;
  logic             grant_next;

  logic [1:0]       busy_b;
  logic [1:0]       fill_start_b;
  logic [1:0]       commit_b;
  logic [1:0]       grant_set_b;
  logic [1:0]       drop_b;
  logic [1:0]       consume_b;
  logic [1:0]       locked_b;

  assign rise = write_active && !write_active_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= W_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // NOTE: every signal gets a default before the case so no latch is inferred.
  always_comb begin
    state_next = state;
    fill_start = 1'b0;
    start_sel  = ebr_select;
    do_write   = 1'b0;
    ovf_evt    = 1'b0;
    col_evt    = 1'b0;
    commit     = 1'b0;
    unique case (state)
      W_IDLE: begin
        if (rise || pend) begin
          fill_start = 1'b1;
          start_sel  = pend ? pend_sel : ebr_select;
          state_next = W_FILL;
        end
      end
      W_FILL: begin
        if (ebr_wren) begin
          ovf_evt  = (count == FULL_COUNT);
          col_evt  = rd_grant && (rd_bank == fill_bank);
          do_write = !ovf_evt && !col_evt;
        end
        // Level test also closes a fill whose write_active pulse ended while a pending start was queued.
        if (!write_active) begin
          state_next = W_COMMIT;
        end
      end
      W_COMMIT: begin
        commit     = (count != '0) && !collided;
        state_next = W_IDLE;
      end
      default: state_next = W_IDLE;
    endcase
  end

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      busy_b[i]       = (state != W_IDLE) && (fill_bank == 1'(i));
      fill_start_b[i] = fill_start && (start_sel == 1'(i));
      commit_b[i]     = commit && (fill_bank == 1'(i));
      grant_set_b[i]  = !rd_grant && rd_req && (rd_bank == 1'(i)) && bank_valid[i] && !busy_b[i];
      drop_b[i]       = locked_b[i] && !rd_req;
      consume_b[i]    = locked_b[i] && rd_done;
    end
    grant_next = (|grant_set_b) || (rd_grant && rd_req && !rd_done);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_active_q <= 1'b0;
      pend           <= 1'b0;
      pend_sel       <= 1'b0;
      fill_bank      <= 1'b0;
      count          <= '0;
      collided       <= 1'b0;
      bank0_wren     <= 1'b0;
      bank1_wren     <= 1'b0;
      wr_addr        <= '0;
      wr_data        <= '0;
      rd_grant       <= 1'b0;
      err_overflow   <= 1'b0;
      err_collision  <= 1'b0;
    end else begin
      write_active_q <= write_active;

      // A start edge arriving during the commit cycle is parked and replayed from W_IDLE.
      if ((state == W_COMMIT) && rise) begin
        pend     <= 1'b1;
        pend_sel <= ebr_select;
      end else if (fill_start) begin
        pend <= 1'b0;
      end

      if (fill_start) begin
        fill_bank <= start_sel;
        count     <= '0;
        collided  <= 1'b0;
      end else if (do_write) begin
        count <= count + 1'b1;
      end

      if (col_evt) begin
        collided <= 1'b1;
      end

      bank0_wren <= do_write && !fill_bank;
      bank1_wren <= do_write && fill_bank;
      if (do_write) begin
        wr_addr <= count[EBR_ADDR_W-1:0];
        wr_data <= ebr_data_in;
      end

      err_overflow  <= (err_overflow && !err_clear) || ovf_evt;
      err_collision <= (err_collision && !err_clear) || col_evt;
      rd_grant      <= grant_next;
    end
  end

  ebr_bank_status #(
    .LEN_W(LEN_W)
  ) u_bank0 (
    .clock     (clock),
    .reset     (reset),
    .fill_start(fill_start_b[0]),
    .commit    (commit_b[0]),
    .commit_len(count),
    .grant_set (grant_set_b[0]),
    .drop      (drop_b[0]),
    .consume   (consume_b[0]),
    .valid     (bank_valid[0]),
    .len       (bank0_len),
    .locked    (locked_b[0])
  );

  ebr_bank_status #(
    .LEN_W(LEN_W)
  ) u_bank1 (
    .clock     (clock),
    .reset     (reset),
    .fill_start(fill_start_b[1]),
    .commit    (commit_b[1]),
    .commit_len(count),
    .grant_set (grant_set_b[1]),
    .drop      (drop_b[1]),
    .consume   (consume_b[1]),
    .valid     (bank_valid[1]),
    .len       (bank1_len),
    .locked    (locked_b[1])
  );

endmodule
